// File: rtl/tick_stopwatch.sv
// tick_stopwatch: mm:ss.t stopwatch advanced by prescaler ticks, with run/pause,
// clear, sticky overflow and a lap hold that freezes the display.

module tick_stopwatch_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] cur,
  input  logic       inc,
  output logic [3:0] nxt,
  output logic       at_max
);
  always_comb begin
    at_max = (cur == MAX);
    nxt    = cur;
    if (inc) nxt = at_max ? 4'd0 : cur + 4'd1;
  end
endmodule

module tick_stopwatch #(
  parameter int TICKS_PER_FRAC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] frac,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);
  localparam int NUM_DIGITS = 5;
  // Digit order, LSD first: frac, sec_ones, sec_tens, min_ones, min_tens.
  localparam logic [NUM_DIGITS-1:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9};
  localparam logic [3:0] DIV_LAST = 4'(TICKS_PER_FRAC - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  typedef struct packed {
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] frac;
  } sw_time_t;

  logic [1:0] state, state_nxt;
  logic [3:0] div, div_nxt;
  logic [NUM_DIGITS-1:0][3:0] live, live_nxt, chain_nxt;
  logic [NUM_DIGITS-1:0] inc, at_max;
  sw_time_t hold;
  logic clr_ok, tick_ok, adv, wrap;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!clear && start_stop) state_nxt = RUN;
      RUN:     if (start_stop) state_nxt = PAUSE;
      PAUSE: begin
        if (clear)           state_nxt = IDLE;
        else if (start_stop) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the registered state gates ticks, so a tick on the edge that starts
  // the run is dropped while one on the edge that pauses it still counts.
  assign clr_ok  = clear && (state != RUN);
  assign tick_ok = tick && (state == RUN);
  assign adv     = tick_ok && (div == DIV_LAST);
  assign wrap    = adv && (&at_max);

  always_comb begin
    div_nxt = div;
    if (clr_ok)       div_nxt = 4'd0;
    else if (adv)     div_nxt = 4'd0;
    else if (tick_ok) div_nxt = div + 4'd1;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign inc[g] = adv;
    end else begin : g_upper
      assign inc[g] = adv && (&at_max[g-1:0]);
    end
    tick_stopwatch_digit #(.MAX(DIG_MAX[g])) u_digit (
      .cur    (live[g]),
      .inc    (inc[g]),
      .nxt    (chain_nxt[g]),
      .at_max (at_max[g])
    );
  end

  assign live_nxt = clr_ok ? '0 : chain_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      div   <= 4'd0;
      live  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      div   <= div_nxt;
      live  <= live_nxt;
      if (clr_ok)    ovf <= 1'b0;
      else if (wrap) ovf <= 1'b1;
    end
  end

  // Lap capture takes the post-edge value so a coincident tick is included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      lap_active <= 1'b0;
    end else if (clr_ok) begin
      hold       <= '0;
      lap_active <= 1'b0;
    end else if (lap) begin
      if (!lap_active) begin
        hold.frac     <= live_nxt[0];
        hold.sec_ones <= live_nxt[1];
        hold.sec_tens <= live_nxt[2][2:0];
        hold.min_ones <= live_nxt[3];
        hold.min_tens <= live_nxt[4][2:0];
      end
      lap_active <= !lap_active;
    end
  end

  assign running  = (state == RUN);
  assign frac     = lap_active ? hold.frac     : live[0];
  assign sec_ones = lap_active ? hold.sec_ones : live[1];
  assign sec_tens = lap_active ? hold.sec_tens : live[2][2:0];
  assign min_ones = lap_active ? hold.min_ones : live[3];
  assign min_tens = lap_active ? hold.min_tens : live[4][2:0];

endmodule

// File: tb/tb_tick_stopwatch.sv
// Scoreboard bench for tick_stopwatch: expectations are queued as stimulus is
// driven and popped against the sampled display when each task finishes.
module tb_tick_stopwatch;
  logic clk = 1'b0, reset = 1'b0, tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;

  logic [3:0] a_frac, a_sec_ones, a_min_ones, b_frac, b_sec_ones, b_min_ones;
  logic [2:0] a_sec_tens, a_min_tens, b_sec_tens, b_min_tens;
  logic       a_running, a_lap_active, a_ovf, b_running, b_lap_active, b_ovf;

  tick_stopwatch #(.TICKS_PER_FRAC(1)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .frac(a_frac), .sec_ones(a_sec_ones), .sec_tens(a_sec_tens), .min_ones(a_min_ones),
    .min_tens(a_min_tens), .running(a_running), .lap_active(a_lap_active), .ovf(a_ovf));

  tick_stopwatch #(.TICKS_PER_FRAC(3)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .frac(b_frac), .sec_ones(b_sec_ones), .sec_tens(b_sec_tens), .min_ones(b_min_ones),
    .min_tens(b_min_tens), .running(b_running), .lap_active(b_lap_active), .ovf(b_ovf));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [20:0] v;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [20:0] obs_a();
    return {a_min_tens, a_min_ones, a_sec_tens, a_sec_ones, a_frac, a_running, a_lap_active, a_ovf};
  endfunction

  function automatic logic [20:0] obs_b();
    return {b_min_tens, b_min_ones, b_sec_tens, b_sec_ones, b_frac, b_running, b_lap_active, b_ovf};
  endfunction

  // Reference display from an elapsed tenths count (wraps every hour).
  function automatic logic [20:0] exp_v(input int tenths, input bit run, input bit lp, input bit ov);
    int t, f, s, m;
    t = tenths % 36000;
    f = t % 10;
    s = (t / 10) % 60;
    m = t / 600;
    return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), 4'(f), run, lp, ov};
  endfunction

  // One cycle of single-cycle pulses, driven just after the edge.
  task automatic cyc(input logic t, input logic s, input logic c, input logic l);
    tick = t; start_stop = s; clear = c; lap = l;
    @(posedge clk); #1;
    tick = 0; start_stop = 0; clear = 0; lap = 0;
  endtask

  task automatic ticks(input int n);
    tick = 1;
    repeat (n) @(posedge clk);
    #1 tick = 0;
  endtask

  task automatic do_reset();
    reset = 1; #2 reset = 0;
  endtask

  task automatic test_reset();
    exp_t e; logic [20:0] g; logic [20:0] got[$];
    reset = 1; #2;
    exp_q.push_back('{name:"reset_a", v:exp_v(0, 0, 0, 0)}); got.push_back(obs_a());
    exp_q.push_back('{name:"reset_b", v:exp_v(0, 0, 0, 0)}); got.push_back(obs_b());
    reset = 0;
    cyc(1, 0, 0, 0);
    exp_q.push_back('{name:"idle_tick_ignored", v:exp_v(0, 0, 0, 0)}); got.push_back(obs_a());
    cyc(0, 1, 0, 0);
    ticks(34);
    exp_q.push_back('{name:"run_0034", v:exp_v(34, 1, 0, 0)}); got.push_back(obs_a());
    reset = 1; #2;
    exp_q.push_back('{name:"reset_mid_run", v:exp_v(0, 0, 0, 0)}); got.push_back(obs_a());
    reset = 0; #1;
    cyc(1, 1, 0, 0);
    exp_q.push_back('{name:"start_tick_dropped", v:exp_v(0, 1, 0, 0)}); got.push_back(obs_a());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask

  task automatic test_count();
    exp_t e; logic [20:0] g; logic [20:0] got[$];
    do_reset();
    cyc(0, 1, 0, 0);
    ticks(9);
    exp_q.push_back('{name:"count_9", v:exp_v(9, 1, 0, 0)}); got.push_back(obs_a());
    ticks(1);
    exp_q.push_back('{name:"count_10_a", v:exp_v(10, 1, 0, 0)}); got.push_back(obs_a());
    exp_q.push_back('{name:"count_10_b", v:exp_v(3, 1, 0, 0)}); got.push_back(obs_b());
    ticks(19);
    exp_q.push_back('{name:"count_29_b", v:exp_v(9, 1, 0, 0)}); got.push_back(obs_b());
    ticks(1);
    exp_q.push_back('{name:"count_30_b", v:exp_v(10, 1, 0, 0)}); got.push_back(obs_b());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask

  task automatic test_wrap();
    exp_t e; logic [20:0] g; logic [20:0] got[$];
    do_reset();
    cyc(0, 1, 0, 0);
    ticks(35999);
    exp_q.push_back('{name:"wrap_5959_9", v:exp_v(35999, 1, 0, 0)}); got.push_back(obs_a());
    ticks(1);
    exp_q.push_back('{name:"wrap_to_zero", v:exp_v(0, 1, 0, 1)}); got.push_back(obs_a());
    ticks(5);
    exp_q.push_back('{name:"ovf_sticky", v:exp_v(5, 1, 0, 1)}); got.push_back(obs_a());
    cyc(0, 1, 0, 0);
    exp_q.push_back('{name:"wrap_pause", v:exp_v(5, 0, 0, 1)}); got.push_back(obs_a());
    cyc(0, 0, 1, 0);
    exp_q.push_back('{name:"clear_ovf", v:exp_v(0, 0, 0, 0)}); got.push_back(obs_a());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask

  task automatic test_pause();
    exp_t e; logic [20:0] g; logic [20:0] got[$];
    do_reset();
    cyc(0, 1, 0, 0);
    ticks(4);
    exp_q.push_back('{name:"pause_pre", v:exp_v(4, 1, 0, 0)}); got.push_back(obs_a());
    cyc(1, 1, 0, 0);
    exp_q.push_back('{name:"pause_tick_counted", v:exp_v(5, 0, 0, 0)}); got.push_back(obs_a());
    ticks(5);
    exp_q.push_back('{name:"pause_hold", v:exp_v(5, 0, 0, 0)}); got.push_back(obs_a());
    cyc(1, 1, 0, 0);
    exp_q.push_back('{name:"resume_tick_dropped", v:exp_v(5, 1, 0, 0)}); got.push_back(obs_a());
    ticks(1);
    exp_q.push_back('{name:"resume_count", v:exp_v(6, 1, 0, 0)}); got.push_back(obs_a());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask

  task automatic test_lap();
    exp_t e; logic [20:0] g; logic [20:0] got[$];
    do_reset();
    cyc(0, 1, 0, 0);
    ticks(23);
    cyc(0, 0, 0, 1);
    exp_q.push_back('{name:"lap_freeze", v:exp_v(23, 1, 1, 0)}); got.push_back(obs_a());
    ticks(5);
    exp_q.push_back('{name:"lap_frozen", v:exp_v(23, 1, 1, 0)}); got.push_back(obs_a());
    cyc(0, 0, 0, 1);
    exp_q.push_back('{name:"lap_release", v:exp_v(28, 1, 0, 0)}); got.push_back(obs_a());
    cyc(1, 0, 0, 1);
    exp_q.push_back('{name:"lap_post_edge", v:exp_v(29, 1, 1, 0)}); got.push_back(obs_a());
    ticks(2);
    cyc(0, 0, 0, 1);
    exp_q.push_back('{name:"lap_release2", v:exp_v(31, 1, 0, 0)}); got.push_back(obs_a());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask

  task automatic test_clear();
    exp_t e; logic [20:0] g; logic [20:0] got[$];
    do_reset();
    cyc(0, 1, 0, 0);
    ticks(7);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    exp_q.push_back('{name:"clear_in_run", v:exp_v(7, 1, 1, 0)}); got.push_back(obs_a());
    ticks(1);
    cyc(0, 0, 0, 1);
    exp_q.push_back('{name:"clear_run_live", v:exp_v(8, 1, 0, 0)}); got.push_back(obs_a());
    cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 0);
    exp_q.push_back('{name:"ss_wins_in_run", v:exp_v(8, 0, 1, 0)}); got.push_back(obs_a());
    cyc(0, 0, 1, 1);
    exp_q.push_back('{name:"clear_beats_lap", v:exp_v(0, 0, 0, 0)}); got.push_back(obs_a());
    cyc(0, 1, 1, 0);
    exp_q.push_back('{name:"clear_wins_idle", v:exp_v(0, 0, 0, 0)}); got.push_back(obs_a());
    cyc(1, 0, 0, 0);
    exp_q.push_back('{name:"idle_after_clear", v:exp_v(0, 0, 0, 0)}); got.push_back(obs_a());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [20:0] g; logic [20:0] got[$];
    do_reset();
    start_stop = 1;
    @(posedge clk); #1;
    exp_q.push_back('{name:"wide_ss_first", v:exp_v(0, 1, 0, 0)}); got.push_back(obs_a());
    tick = 1;
    @(posedge clk); #1;
    start_stop = 0; tick = 0;
    exp_q.push_back('{name:"wide_ss_second", v:exp_v(1, 0, 0, 0)}); got.push_back(obs_a());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_count();
    test_wrap();
    test_pause();
    test_lap();
    test_clear();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
